// File: rtl/pe_pkg.sv
// Shared constants for the PE operand loader: FSM encoding, frame sizing and err bit positions.
package pe_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_KICK = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  localparam int ERR_TLAST   = 0;
  localparam int ERR_TIMEOUT = 1;

  // One frame is vector A followed by vector B.
  function automatic int frame_words(input int vector_size);
    return 2 * vector_size;
  endfunction

  localparam int FRAME_WORDS = frame_words(16);

endpackage

// File: rtl/pe_result_slice.sv
// Single-entry valid/ready output register holding the PE result until the consumer takes it.
module pe_result_slice #(
  parameter int SIZE = 8
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            load,
  input  logic [SIZE-1:0] load_data,
  input  logic            ready,
  output logic [SIZE-1:0] data,
  output logic            valid
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_vec_loader.sv
// Streams one A/B operand frame into the PE BRAM, kicks the PE controller and returns its result.
// Optional PE_TIMEOUT_EN adds a WAIT watchdog that forces a zero result and flags err[1].
module pe_vec_loader
  import pe_pkg::*;
#(
  parameter int SIZE           = 8,
  parameter int VECTOR_SIZE    = 16,
  parameter int L_RAM_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [SIZE-1:0]       s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic                  bram_we,
  output logic [L_RAM_SIZE:0]   bram_addr,
  output logic [SIZE-1:0]       bram_wdata,
  output logic                  pe_start,
  input  logic                  pe_done,
  input  logic [SIZE-1:0]       pe_result,
  output logic [SIZE-1:0]       m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam int AW      = L_RAM_SIZE + 1;
  localparam int FRAME_N = frame_words(VECTOR_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_N - 1);

  logic [2:0]      state;
  logic [AW-1:0]   cnt;
  logic            accept;
  logic            last_word;
  logic            wd_hit;
  logic            res_load;
  logic [SIZE-1:0] res_data;

  assign s_tready  = (state == S_FILL);
  assign busy      = (state != S_IDLE);
  assign accept    = s_tvalid && s_tready;
  assign last_word = (cnt == LAST_IDX);

`ifdef PE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Cleared in KICK so the count starts at zero on the first WAIT cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)              wd <= '0;
    else if (state == S_KICK)  wd <= '0;
    else if (state == S_WAIT)  wd <= wd + WD_W'(1);
  end

  assign wd_hit = (state == S_WAIT) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the comparison folds to zero and only keeps the parameter referenced.
  assign wd_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign res_load = (state == S_WAIT) && (pe_done || wd_hit);
  assign res_data = pe_done ? pe_result : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      pe_start   <= 1'b0;
      err        <= '0;
    end else begin
      bram_we  <= accept;
      pe_start <= 1'b0;
      if (accept) begin
        bram_addr  <= cnt;
        bram_wdata <= s_tdata;
      end
      if (res_load && !pe_done) err[ERR_TIMEOUT] <= 1'b1;
      case (state)
        S_IDLE: if (enable) state <= S_FILL;
        S_FILL: if (accept) begin
          if (last_word) begin
            cnt   <= '0;
            state <= S_KICK;
            if (!s_tlast) err[ERR_TLAST] <= 1'b1;
          end else if (s_tlast) begin
            // Short frame: restart at address 0 and keep filling.
            cnt            <= '0;
            err[ERR_TLAST] <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        // Final write commits at this edge, so the start pulse lands after it.
        S_KICK: begin
          state    <= S_WAIT;
          pe_start <= 1'b1;
        end
        S_WAIT: if (res_load) state <= S_SEND;
        S_SEND: if (m_tvalid && m_tready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  pe_result_slice #(.SIZE(SIZE)) u_slice (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (res_load),
    .load_data (res_data),
    .ready     (m_tready),
    .data      (m_tdata),
    .valid     (m_tvalid)
  );

endmodule

// File: tb/tb_pe_vec_loader.sv
// Directed bench for pe_vec_loader: table of frames plus reset-abort and watchdog sequences.
module tb_pe_vec_loader;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic       bram_we;
  logic [4:0] bram_addr;
  logic [7:0] bram_wdata;
  logic       pe_start;
  logic       pe_done = 1'b0;
  logic [7:0] pe_result = '0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       busy;
  logic [1:0] err;

  always #5 aclk = ~aclk;

  pe_vec_loader #(.SIZE(8), .VECTOR_SIZE(16), .L_RAM_SIZE(4), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .pe_start(pe_start), .pe_done(pe_done), .pe_result(pe_result),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Write scoreboard: every accept must show up as a BRAM write in the next cycle.
  logic [7:0] mem [32];
  int         cyc = 0, starts = 0, last_fin = -100, mcnt = 0;
  bit         pend = 1'b0;
  logic [4:0] paddr = '0;
  logic [7:0] pdata = '0;

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      pend = 1'b0;
      mcnt = 0;
    end else begin
      if (pend) begin
        chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, paddr);
        chk("wr_data", bram_wdata, pdata);
        mem[bram_addr] = bram_wdata;
      end else begin
        chk("idle_we", bram_we, 0);
      end
      if (pe_start) begin
        starts++;
        chk("start_lat", cyc - last_fin, 2);
        chk("wait_tready", s_tready, 0);
      end
      pend = s_tvalid && s_tready;
      if (pend) begin
        paddr = 5'(mcnt);
        pdata = s_tdata;
        if (mcnt == 31) last_fin = cyc;
        mcnt = (mcnt == 31 || s_tlast) ? 0 : mcnt + 1;
      end
    end
  end

  task automatic send_words(input logic [7:0] base, input int n, input int tlast_at, input bit gaps);
    bit ok;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) step();
      end
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i);
      s_tlast  = (i == tlast_at);
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 100) begin
        @(negedge aclk);
        ok = s_tready;
        step();
        t++;
      end
      chk("accept_seen", ok, 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int t = 0;
    ok = 1'b0;
    while (!ok && t < 20) begin
      @(negedge aclk);
      ok = pe_start;
      t++;
    end
    chk("start_seen", ok, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_we"}, bram_we, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_wdata"}, bram_wdata, 0);
    chk({tag, "_start"}, pe_start, 0);
    chk({tag, "_mdata"}, m_tdata, 0);
    chk({tag, "_mvalid"}, m_tvalid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  typedef struct {
    logic [7:0] base;
    int         pre_n;
    bit         gaps;
    bit         no_tlast;
    logic [7:0] result;
    int         rdly;
    logic [1:0] exp_err;
  } frame_t;

  frame_t tbl [5];

  task automatic run_frame(input frame_t r);
    int s0;
    bit ok;
    s0 = starts;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    enable = 1'b1;
    if (r.pre_n > 0) send_words(8'h70, r.pre_n, r.pre_n - 1, 1'b0);
    send_words(r.base, 32, r.no_tlast ? -1 : 31, r.gaps);
    enable = 1'b0;
    wait_start(ok);
    step();
    pe_done = 1'b1;
    pe_result = r.result;
    step();
    pe_done = 1'b0;
    pe_result = 8'hEE;
    m_tready = 1'b0;
    for (int k = 0; k < r.rdly; k++) begin
      @(negedge aclk);
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, r.result);
      chk("send_tready", s_tready, 0);
      chk("send_busy", busy, 1);
      step();
    end
    m_tready = 1'b1;
    @(negedge aclk);
    chk("hs_valid", m_tvalid, 1);
    chk("hs_data", m_tdata, r.result);
    step();
    m_tready = 1'b0;
    @(negedge aclk);
    chk("post_valid", m_tvalid, 0);
    chk("post_busy", busy, 0);
    chk("post_tready", s_tready, 0);
    // A completion pulse outside WAIT must be ignored.
    step();
    pe_done = 1'b1;
    pe_result = 8'h77;
    step();
    pe_done = 1'b0;
    @(negedge aclk);
    chk("idle_done_valid", m_tvalid, 0);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_data", m_tdata, r.result);
    chk("frame_err", err, r.exp_err);
    chk("frame_starts", starts - s0, 1);
    for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], 8'(r.base + i));
    step();
  endtask

  initial begin
    bit ok;
    int s0, n;
    tbl[0] = '{8'h01, 0,  1'b0, 1'b0, 8'h5A, 3, 2'b00};
    tbl[1] = '{8'hA0, 10, 1'b0, 1'b0, 8'h3C, 0, 2'b01};
    tbl[2] = '{8'h40, 0,  1'b1, 1'b0, 8'hC3, 1, 2'b01};
    tbl[3] = '{8'h10, 0,  1'b0, 1'b0, 8'h81, 2, 2'b00};
    tbl[4] = '{8'hD0, 0,  1'b1, 1'b1, 8'h24, 0, 2'b01};

    #3 aresetn = 1'b0;
    #1 chk_reset_outs("rst0");
    step();
    step();
    aresetn = 1'b1;
    step();

    for (int i = 0; i < 3; i++) run_frame(tbl[i]);

    // Reset in the middle of filling: abandon the frame, no start pulse.
    enable = 1'b1;
    send_words(8'h90, 20, -1, 1'b0);
    @(negedge aclk);
    s0 = starts;
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1 chk_reset_outs("rst_mid");
    repeat (3) step();
    aresetn = 1'b1;
    chk("rst_idle_busy", busy, 0);
    repeat (4) step();
    chk("rst_no_start", starts - s0, 0);

    for (int i = 3; i < 5; i++) run_frame(tbl[i]);

    // PE never answers.
    enable = 1'b1;
    send_words(8'h60, 32, 31, 1'b0);
    enable = 1'b0;
    wait_start(ok);
`ifdef PE_TIMEOUT_EN
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge aclk);
      n++;
      ok = m_tvalid;
    end
    chk("to_lat", n, 8);
    chk("to_data", m_tdata, 0);
    chk("to_err1", err[1], 1);
    step();
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    @(negedge aclk);
    chk("to_done_busy", busy, 0);
`else
    n = 0;
    repeat (40) @(negedge aclk);
    chk("nto_valid", m_tvalid, 0);
    chk("nto_busy", busy, 1);
    chk("nto_err1", err[1], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
